// File: rtl/tmr_cap_ctrl.sv
// Input-capture controller: synchronizes a capture pin, detects the selected edges
// and pushes the live counter value into a small FIFO with overflow and IRQ flags.
module tmr_cap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic [1:0]                    edge_sel_i,
  input  logic                          clr_i,
  input  logic                          capch_i,
  input  logic [DATA_WIDTH-1:0]         cnt_i,
  output logic [DATA_WIDTH-1:0]         cap_data_o,
  output logic                          cap_valid_o,
  input  logic                          cap_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          ovf_o,
  input  logic                          irq_en_i,
  output logic                          irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    SEL_RISE = 2'b00,
    SEL_FALL = 2'b01,
    SEL_BOTH = 2'b10,
    SEL_NONE = 2'b11
  } edge_sel_e;

  logic          s0_q, s0_d;
  logic          s1_q, s1_d;
  logic          p_q, p_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic rise, fall, sel_hit, ev, pop, full, wr_en, rd_en;

  // Synchronizer and edge-history flop run regardless of en_i so that enabling
  // capture never sees a stale level difference as an edge.
  always_comb begin
    s0_d = capch_i;
    s1_d = s0_q;
    p_d  = s1_q;
  end

  always_comb begin
    rise    = s1_q & ~p_q;
    fall    = ~s1_q & p_q;
    sel_hit = 1'b0;
    case (edge_sel_e'(edge_sel_i))
      SEL_RISE: sel_hit = rise;
      SEL_FALL: sel_hit = fall;
      SEL_BOTH: sel_hit = rise | fall;
      default:  sel_hit = 1'b0;
    endcase
    ev = en_i & sel_hit;
  end

  always_comb begin
    cap_valid_o = (cnt_q != '0);
    full        = (cnt_q == CW'(FIFO_DEPTH));
    pop         = cap_valid_o & cap_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    wr_en       = ev & ~clr_i & (~full | pop);
    rd_en       = pop & ~clr_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    irq_d    = irq_en_i & (cap_valid_o | ovf_q);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (ev & full & ~pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      p_q      <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      p_q      <= p_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= cnt_i;
  end

  assign cap_data_o = mem_q[rd_ptr_q];
  assign fifo_cnt_o = cnt_q;
  assign ovf_o      = ovf_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_tmr_cap_ctrl.sv
// Bench for tmr_cap_ctrl: directed scenarios then random traffic, all checked
// against a queue-based model of pin samples, FIFO contents and flags.
module tb_tmr_cap_ctrl;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic          clr = 1'b0;
  logic          capch = 1'b0;
  logic [DW-1:0] cnt = '0;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready = 1'b0;
  logic [CW-1:0] fcnt;
  logic          ovf;
  logic          irq_en = 1'b0;
  logic          irq;

  int total = 0;
  int bad   = 0;

  // model: captured values, flags, and the last three sampled pin levels
  int unsigned mq[$];
  bit m_ovf = 0;
  bit m_irq = 0;
  bit ph[3] = '{0, 0, 0};

  tmr_cap_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .edge_sel_i(sel), .clr_i(clr),
    .capch_i(capch), .cnt_i(cnt), .cap_data_o(data), .cap_valid_o(valid),
    .cap_ready_i(ready), .fifo_cnt_o(fcnt), .ovf_o(ovf), .irq_en_i(irq_en),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 0;
    m_irq = 0;
    ph = '{0, 0, 0};
  endtask

  task automatic cmp_all();
    chk("valid", valid, mq.size() != 0);
    chk("fcnt", fcnt, mq.size());
    chk("ovf", ovf, m_ovf);
    chk("irq", irq, m_irq);
    if (mq.size() != 0) chk("data", data, mq[0]);
  endtask

  // A pin level sampled at edge n reaches the detector two edges later;
  // an edge is a difference between the samples taken two and three edges back.
  task automatic tick();
    bit lvl_new, lvl_old, e, pp, irq_n;
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      lvl_new = ph[1];
      lvl_old = ph[2];
      case (sel)
        2'b00:   e = lvl_new && !lvl_old;
        2'b01:   e = !lvl_new && lvl_old;
        2'b10:   e = lvl_new != lvl_old;
        default: e = 0;
      endcase
      e = e && en;
      pp = (mq.size() != 0) && ready;
      irq_n = irq_en && ((mq.size() != 0) || m_ovf);
      if (clr) begin
        mq.delete();
        m_ovf = 0;
      end else begin
        if (pp) void'(mq.pop_front());
        if (e) begin
          if (mq.size() < D) mq.push_back(cnt);
          else m_ovf = 1;
        end
      end
      m_irq = irq_n;
      ph[2] = ph[1];
      ph[1] = ph[0];
      ph[0] = capch;
    end
    #1;
    cnt = cnt + 1;
    cmp_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_fcnt", fcnt, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_irq", irq, 1'b0);
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse_rise();
    capch = 1'b1;
    ticks(2);
    capch = 1'b0;
    ticks(2);
  endtask

  initial begin
    int unsigned t0, d0, d1, pops;
    // reset state
    do_reset();
    ticks(2);

    // first-capture latency and irq timing
    en = 1'b1; sel = 2'b00; irq_en = 1'b1;
    capch = 1'b1;
    t0 = cnt;
    ticks(2);
    chk("lat_not_yet", valid, 1'b0);
    tick();
    chk("lat_valid", valid, 1'b1);
    chk("lat_data", data, t0 + 2);
    chk("lat_irq_pre", irq, 1'b0);
    tick();
    chk("lat_irq", irq, 1'b1);
    ready = 1'b1; tick(); ready = 1'b0;
    capch = 1'b0; ticks(4);

    // both edges, 5-cycle pulse
    sel = 2'b10;
    capch = 1'b1; ticks(5);
    capch = 1'b0; ticks(5);
    chk("both_fcnt", fcnt, 2);
    chk("both_ovf", ovf, 1'b0);
    d0 = data;
    ready = 1'b1; tick(); ready = 1'b0;
    d1 = data;
    chk("both_delta", d1 - d0, 5);
    ready = 1'b1; tick(); ready = 1'b0;

    // six rising edges, no pops: overflow keeps the first four
    sel = 2'b00;
    for (int i = 0; i < 6; i++) pulse_rise();
    ticks(3);
    chk("ovf_fcnt", fcnt, D);
    chk("ovf_flag", ovf, 1'b1);
    pops = 0;
    ready = 1'b1;
    for (int i = 0; i < 10 && valid; i++) begin
      tick();
      pops++;
    end
    ready = 1'b0;
    chk("drain_pops", pops, D);
    chk("drain_empty", valid, 1'b0);
    chk("drain_ovf_sticky", ovf, 1'b1);

    // clear coincident with an event
    capch = 1'b1; ticks(2);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_fcnt", fcnt, 0);
    chk("clr_ovf", ovf, 1'b0);
    tick();
    chk("clr_irq", irq, 1'b0);
    capch = 1'b0; ticks(3);

    // full FIFO, event coinciding with a pop
    for (int i = 0; i < D; i++) pulse_rise();
    chk("full_fcnt", fcnt, D);
    capch = 1'b1; ticks(2);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("fullpop_fcnt", fcnt, D);
    chk("fullpop_ovf", ovf, 1'b0);
    capch = 1'b0; ticks(3);

    // disabled toggling, then enable with stable pin
    en = 1'b0;
    ready = 1'b1; tick(); ready = 1'b0;
    for (int i = 0; i < 4; i++) begin capch = ~capch; ticks(2); end
    capch = 1'b1; ticks(4);
    en = 1'b1; ticks(4);
    chk("en_no_cap", fcnt, 3);
    do_reset();
    chk("rst_mid_valid", valid, 1'b0);
    ticks(4);

    // capch held high through reset release gives one rising event
    capch = 1'b1;
    do_reset();
    ticks(4);
    chk("rst_hi_rise", fcnt, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) capch = ~capch;
      if ($urandom_range(15) == 0) sel = 2'($urandom_range(3));
      if ($urandom_range(31) == 0) en = ~en;
      if ($urandom_range(31) == 0) irq_en = ~irq_en;
      ready = ($urandom_range(2) == 0);
      clr = ($urandom_range(63) == 0);
      if ($urandom_range(499) == 0) begin
        clr = 1'b0;
        do_reset();
      end else tick();
    end
    clr = 1'b0; ready = 1'b0;
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmr_cap_ctrl.md
TMR_CAP_CTRL -- requirements
Module: tmr_cap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the captured counter value.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, a power of 2 and at least 2: capture FIFO entries.
REQ-003 SHALL have the port clk_i, input, 1 bit: the single clock; the block SHALL use one clock only.
REQ-004 SHALL have the port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have the port en_i, input, 1 bit: capture enable.
REQ-006 SHALL have the port edge_sel_i, input, 2 bits: 00 rising, 01 falling, 10 both edges, 11 none.
REQ-007 SHALL have the port clr_i, input, 1 bit: synchronous flush of the FIFO and of ovf_o.
REQ-008 SHALL have the port capch_i, input, 1 bit: asynchronous capture channel pin.
REQ-009 SHALL have the port cnt_i, input, DATA_WIDTH bits: live counter value from the timer core.
REQ-010 SHALL have the port cap_data_o, output, DATA_WIDTH bits: FIFO head value.
REQ-011 SHALL have the port cap_valid_o, output, 1 bit: FIFO not empty.
REQ-012 SHALL have the port cap_ready_i, input, 1 bit: pop the head when cap_valid_o is high.
REQ-013 SHALL have the port fifo_cnt_o, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have the port ovf_o, output, 1 bit: sticky flag, set when a capture is lost.
REQ-015 SHALL have the port irq_en_i, input, 1 bit: interrupt enable.
REQ-016 SHALL have the port irq_o, output, 1 bit: registered interrupt request.

Function
REQ-017 capch_i SHALL pass through a 2-flop synchronizer (s0, s1); a register p SHALL follow s1 every cycle regardless of en_i.
REQ-018 Edge detection SHALL use the s1/p pair:
- rise = s1 & ~p
- fall = ~s1 & p
- ev = en_i & selected edge(s) per edge_sel_i
REQ-019 Push timing: on a cycle with ev high, cnt_i SHALL be written into the FIFO at the next clk_i edge.
- Latency: if capch_i changes before clock edge 1, ev is high after edge 2 and cap_valid_o is high after edge 3.
- The stored value is cnt_i as sampled at edge 3.
REQ-020 Pop: when cap_valid_o and cap_ready_i are both high at a clock edge, the head SHALL be removed; cap_ready_i with an empty FIFO SHALL be a no-op.
REQ-021 Push into a full FIFO SHALL be accepted only if a pop occurs in the same cycle; occupancy SHALL then remain FIFO_DEPTH.
REQ-022 Push into a full FIFO without a simultaneous pop SHALL be dropped and SHALL set ovf_o; the FIFO contents SHALL be unchanged.
REQ-023 Simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_cnt_o SHALL range 0..FIFO_DEPTH.
REQ-025 cap_data_o SHALL show the oldest entry whenever cap_valid_o is high; it is don't-care when the FIFO is empty.
REQ-026 clr_i SHALL take priority over push and pop: at the next edge, occupancy = 0 and ovf_o = 0, and any coincident event is discarded.
REQ-027 ovf_o SHALL remain set until clr_i or reset.
REQ-028 irq_o SHALL be registered as irq_en_i & (cap_valid_o | ovf_o), i.e. one cycle after the flag state it reflects.
REQ-029 edge_sel_i = 11 or en_i low SHALL suppress all pushes; the synchronizer and p SHALL keep running, so that a later enable produces no spurious edge.
REQ-030 Changing edge_sel_i SHALL take effect on the next cycle's ev evaluation; no event SHALL be double-counted.

Reset
REQ-031 While rst_n_i is low:
- s0, s1, p, the pointers, fifo_cnt_o, ovf_o and irq_o SHALL be 0.
- cap_valid_o SHALL be 0.
- FIFO storage need not be reset.
REQ-032 Reset asserted mid-operation SHALL discard pending captures immediately; after release, the first capture requires a fresh edge.
- capch_i held high through reset release SHALL produce a rising event (p=0, s1 becomes 1) if enabled.

Verification
REQ-033 en_i=1, edge_sel_i=00, cnt_i=cycle counter; capch_i rises before edge 10 -> cap_valid_o=1 after edge 12, cap_data_o = cnt_i value at edge 12, irq_o=1 after edge 13 with irq_en_i=1.
REQ-034 edge_sel_i=10, one high pulse 5 cycles wide, FIFO_DEPTH=4 -> two entries whose values differ by 5, fifo_cnt_o=2, ovf_o=0.
REQ-035 Six rising edges with no pops, FIFO_DEPTH=4 -> fifo_cnt_o=4, ovf_o=1, the first four values are retained in order, and draining yields 4 pops before cap_valid_o=0.
REQ-036 FIFO full plus a capture event coinciding with a pop -> fifo_cnt_o stays 4, ovf_o stays 0, the new value appears last.
REQ-037 Overflow, then clr_i pulsed in the same cycle as an event -> next cycle fifo_cnt_o=0, ovf_o=0, irq_o=0 one cycle later.
REQ-038 Toggle capch_i while en_i=0, then set en_i=1 with capch_i stable -> no capture; rst_n_i pulsed with 3 entries pending -> cap_valid_o=0 immediately.
